// File: rtl/adc_spi_slave_mc.sv
// adc_spi_slave_mc: mode-0 SPI register slave in front of a multi-channel ADC.
// Define ADC_SPI_IRQ_EN to build the IRQ_MASK register and the irq output.
module adc_spi_slave_mc #(
  parameter int DATA_W = 12,
  parameter int NCH    = 4,
  parameter int ADDR_W = 3,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              cs,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] adc_data_in,
  input  logic [CH_W-1:0]   adc_ch_in,
  input  logic              adc_busy_in,
  input  logic              adc_eoc_pulse,
  input  logic              hw_clear_start,
  output logic [DATA_W-1:0] ctrl_reg_out,
  output logic [NCH-1:0]    eoc_flags_out,
  output logic              irq
);

  localparam int HDR_W = 2 + ADDR_W;
  localparam int FL    = HDR_W + DATA_W;
  localparam int CNT_W = $clog2(FL + 1);

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_SET   = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_INFO   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(3);
  localparam logic [DATA_W-1:0] INFO_VAL = DATA_W'((NCH << 4) | 11);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, EXEC = 2'd2} state_t;

  function automatic logic [DATA_W-1:0] wr_merge(input logic [DATA_W-1:0] cur,
                                                 input logic [1:0] cmd,
                                                 input logic [DATA_W-1:0] pay);
    case (cmd)
      CMD_WRITE: wr_merge = pay;
      CMD_SET:   wr_merge = cur | pay;
      CMD_CLEAR: wr_merge = cur & ~pay;
      default:   wr_merge = cur;
    endcase
  endfunction

  logic [2:0]        sck_sync_q, eoc_sync_q;
  logic [1:0]        cs_sync_q;
  state_t            state_q;
  logic              armed_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [FL-1:0]     frame_q;
  logic [DATA_W-1:0] miso_q;
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic [NCH-1:0]    eoc_q, eoc_d, ovr_q, ovr_d;
  logic [DATA_W-1:0] data_q [NCH];
  logic [DATA_W-1:0] rd_val_s, status_s, mask_rd_s;

  wire cs_s       = cs_sync_q[1];
  wire sck_rise_s = sck_sync_q[1] & ~sck_sync_q[2];
  wire sck_fall_s = ~sck_sync_q[1] & sck_sync_q[2];
  wire eoc_rise_s = eoc_sync_q[1] & ~eoc_sync_q[2];
  wire exec_s     = (state_q == EXEC);
  wire [1:0]        ex_cmd_s   = frame_q[FL-1 -: 2];
  wire [ADDR_W-1:0] ex_addr_s  = frame_q[DATA_W +: ADDR_W];
  wire [DATA_W-1:0] ex_pay_s   = frame_q[DATA_W-1:0];
  wire [1:0]        hdr_cmd_s  = frame_q[HDR_W-1 -: 2];
  wire [ADDR_W-1:0] hdr_addr_s = frame_q[ADDR_W-1:0];

  // Two-flop synchronisers; the third sck/eoc stage only feeds edge detection
  always_ff @(posedge clk) begin
    if (!reset_) begin
      sck_sync_q <= 3'b000;
      eoc_sync_q <= 3'b000;
      cs_sync_q  <= 2'b00;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], sck};
      eoc_sync_q <= {eoc_sync_q[1:0], adc_eoc_pulse};
      cs_sync_q  <= {cs_sync_q[0], cs};
    end
  end

  // Read mux, evaluated when the header has just been received
  always_comb begin
    status_s = DATA_W'({ovr_q, eoc_q, adc_busy_in});
    rd_val_s = {DATA_W{1'b0}};
    if (hdr_addr_s == A_CTRL) begin
      rd_val_s = ctrl_q;
    end else if (hdr_addr_s == A_STATUS) begin
      rd_val_s = status_s;
    end else if (hdr_addr_s == A_INFO) begin
      rd_val_s = INFO_VAL;
    end else if (hdr_addr_s == A_MASK) begin
      rd_val_s = mask_rd_s;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (hdr_addr_s == ADDR_W'(k + 4)) rd_val_s = data_q[k];
      end
    end
  end

  // Frame FSM; armed_q demands cs high before any new frame is accepted
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      bit_cnt_q <= {CNT_W{1'b0}};
      frame_q   <= {FL{1'b0}};
      miso_q    <= {DATA_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q   <= SHIFT;
            armed_q   <= 1'b0;
            bit_cnt_q <= {CNT_W{1'b0}};
            frame_q   <= {FL{1'b0}};
            miso_q    <= {DATA_W{1'b0}};
          end
        end
        SHIFT: begin
          if (cs_s) begin
            state_q <= IDLE;
          end else if (sck_rise_s) begin
            frame_q   <= {frame_q[FL-2:0], mosi};
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(FL - 1)) state_q <= EXEC;
          end else if (sck_fall_s) begin
            if (bit_cnt_q == CNT_W'(HDR_W))
              miso_q <= (hdr_cmd_s == CMD_READ) ? rd_val_s : {DATA_W{1'b0}};
            else if (bit_cnt_q > CNT_W'(HDR_W))
              miso_q <= {miso_q[DATA_W-2:0], 1'b0};
          end
        end
        EXEC:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next state of CTRL/IRQ_MASK and the per-channel eoc/ovr flags
  always_comb begin
    ctrl_d = ctrl_q;
    eoc_d  = eoc_q;
    ovr_d  = ovr_q;
    if (exec_s && ex_addr_s == A_CTRL) ctrl_d = wr_merge(ctrl_q, ex_cmd_s, ex_pay_s);
    else ctrl_d = ctrl_q;
    if (hw_clear_start) ctrl_d[1] = 1'b0;
    else ctrl_d[1] = ctrl_d[1];
    for (int k = 0; k < NCH; k++) begin
      // A same-cycle EOC beats the read-clear and leaves ovr alone
      if (eoc_rise_s && adc_ch_in == CH_W'(k)) begin
        eoc_d[k] = 1'b1;
        if (eoc_q[k] && !(exec_s && ex_cmd_s == CMD_READ && ex_addr_s == ADDR_W'(k + 4)))
          ovr_d[k] = 1'b1;
        else
          ovr_d[k] = ovr_q[k];
      end else if (exec_s && ex_cmd_s == CMD_READ && ex_addr_s == ADDR_W'(k + 4)) begin
        eoc_d[k] = 1'b0;
        ovr_d[k] = 1'b0;
      end else begin
        eoc_d[k] = eoc_q[k];
        ovr_d[k] = ovr_q[k];
      end
    end
  end

  // Register file and captured conversion results
  always_ff @(posedge clk) begin
    if (!reset_) begin
      ctrl_q <= {DATA_W{1'b0}};
      eoc_q  <= {NCH{1'b0}};
      ovr_q  <= {NCH{1'b0}};
      for (int k = 0; k < NCH; k++) data_q[k] <= {DATA_W{1'b0}};
    end else begin
      ctrl_q <= ctrl_d;
      eoc_q  <= eoc_d;
      ovr_q  <= ovr_d;
      for (int k = 0; k < NCH; k++) begin
        if (eoc_rise_s && adc_ch_in == CH_W'(k)) data_q[k] <= adc_data_in;
      end
    end
  end

`ifdef ADC_SPI_IRQ_EN
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              irq_q;

  // IRQ_MASK next state
  always_comb begin
    if (exec_s && ex_addr_s == A_MASK) mask_d = wr_merge(mask_q, ex_cmd_s, ex_pay_s);
    else mask_d = mask_q;
  end

  // Mask register and registered interrupt
  always_ff @(posedge clk) begin
    if (!reset_) begin
      mask_q <= {DATA_W{1'b0}};
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |(eoc_q & mask_q[NCH-1:0]);
    end
  end

  assign mask_rd_s = mask_q;
  assign irq       = irq_q;
`else
  assign mask_rd_s = {DATA_W{1'b0}};
  assign irq       = 1'b0;
`endif

  assign miso          = cs ? 1'bz : miso_q[DATA_W-1];
  assign ctrl_reg_out  = ctrl_q;
  assign eoc_flags_out = eoc_q;

endmodule

// File: tb/tb_adc_spi_slave_mc.sv
// Directed bench for adc_spi_slave_mc: SPI register access, EOC capture,
// overrun, aborted frames, hw_clear_start priority, irq and mid-frame reset.
module tb_adc_spi_slave_mc;
  localparam int DATA_W = 12;
  localparam int NCH    = 4;
  localparam int ADDR_W = 3;
  localparam int HDR_W  = 2 + ADDR_W;
  localparam int FL     = HDR_W + DATA_W;
  localparam int HALF   = 6;

  logic clk = 1'b0;
  logic reset_, cs, sck, mosi, miso;
  logic [DATA_W-1:0] adc_data_in, ctrl_reg_out;
  logic [1:0] adc_ch_in;
  logic adc_busy_in, adc_eoc_pulse, hw_clear_start, irq;
  logic [NCH-1:0] eoc_flags_out;
  logic [DATA_W-1:0] rd;
  int total = 0;
  int bad = 0;

  adc_spi_slave_mc #(.DATA_W(DATA_W), .NCH(NCH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_(reset_), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
    .adc_data_in(adc_data_in), .adc_ch_in(adc_ch_in), .adc_busy_in(adc_busy_in),
    .adc_eoc_pulse(adc_eoc_pulse), .hw_clear_start(hw_clear_start),
    .ctrl_reg_out(ctrl_reg_out), .eoc_flags_out(eoc_flags_out), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clocks nbits of a frame; optionally pulses hw_clear_start in the EXEC cycle
  task automatic shift_bits(input logic [FL-1:0] fr, input int nbits, input logic clr,
                            output logic [DATA_W-1:0] data);
    data = {DATA_W{1'b0}};
    for (int i = 0; i < nbits; i++) begin
      mosi = fr[FL-1-i];
      clk_n(HALF);
      if (i >= HDR_W) data = {data[DATA_W-2:0], miso};
      sck = 1'b1;
      if (clr && i == FL - 1) begin
        clk_n(3);
        hw_clear_start = 1'b1;
        clk_n(1);
        hw_clear_start = 1'b0;
        clk_n(HALF - 4);
      end else begin
        clk_n(HALF);
      end
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] pay, input int nbits, input logic clr,
                      output logic [DATA_W-1:0] data);
    cs = 1'b0;
    clk_n(6);
    shift_bits({cmd, addr, pay}, nbits, clr, data);
    clk_n(HALF);
    cs = 1'b1;
    clk_n(8);
  endtask

  task automatic eoc(input logic [1:0] ch, input logic [DATA_W-1:0] d);
    adc_ch_in = ch;
    adc_data_in = d;
    clk_n(1);
    adc_eoc_pulse = 1'b1;
    clk_n(4);
    adc_eoc_pulse = 1'b0;
    clk_n(6);
  endtask

  initial begin
    reset_ = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    adc_data_in = 12'h000; adc_ch_in = 2'd0; adc_busy_in = 1'b0;
    adc_eoc_pulse = 1'b0; hw_clear_start = 1'b0;
    clk_n(4);
    reset_ = 1'b1;
    clk_n(8);
    check("reset_ctrl", ctrl_reg_out, 32'h0);
    check("reset_eoc", eoc_flags_out, 32'h0);
    check("reset_irq", irq, 32'h0);

    xfer(2'b00, 3'd2, 12'h000, FL, 1'b0, rd);
    check("info", rd, 32'h04B);

    xfer(2'b01, 3'd0, 12'h0A5, FL, 1'b0, rd);
    check("wr_ctrl_out", ctrl_reg_out, 32'h0A5);
    xfer(2'b00, 3'd0, 12'h000, FL, 1'b0, rd);
    check("rd_ctrl", rd, 32'h0A5);

    xfer(2'b01, 3'd2, 12'hFFF, FL, 1'b0, rd);
    xfer(2'b00, 3'd2, 12'h000, FL, 1'b0, rd);
    check("info_ro", rd, 32'h04B);
    xfer(2'b01, 3'd1, 12'hFFF, FL, 1'b0, rd);
    xfer(2'b00, 3'd1, 12'h000, FL, 1'b0, rd);
    check("status_idle", rd, 32'h000);

    adc_busy_in = 1'b1;
    eoc(2'd2, 12'hABC);
    check("eoc2_flag", eoc_flags_out, 32'h4);
    xfer(2'b00, 3'd1, 12'h000, FL, 1'b0, rd);
    check("status_eoc2", rd, 32'h009);
    xfer(2'b00, 3'd6, 12'h000, FL, 1'b0, rd);
    check("data2", rd, 32'hABC);
    check("eoc2_cleared", eoc_flags_out, 32'h0);
    xfer(2'b00, 3'd1, 12'h000, FL, 1'b0, rd);
    check("status_after_rd2", rd, 32'h001);

    eoc(2'd1, 12'h111);
    eoc(2'd1, 12'h222);
    check("eoc1_flag", eoc_flags_out, 32'h2);
    xfer(2'b00, 3'd1, 12'h000, FL, 1'b0, rd);
    check("status_ovr1", rd, 32'h045);
    xfer(2'b00, 3'd5, 12'h000, FL, 1'b0, rd);
    check("data1_latest", rd, 32'h222);
    check("eoc1_cleared", eoc_flags_out, 32'h0);
    xfer(2'b00, 3'd1, 12'h000, FL, 1'b0, rd);
    check("status_ovr1_cleared", rd, 32'h001);

    xfer(2'b01, 3'd0, 12'hFFF, 9, 1'b0, rd);
    check("abort_ctrl", ctrl_reg_out, 32'h0A5);
    xfer(2'b00, 3'd0, 12'h000, FL, 1'b0, rd);
    check("rd_after_abort", rd, 32'h0A5);

    xfer(2'b11, 3'd0, 12'h0A0, FL, 1'b0, rd);
    check("clear_ctrl", ctrl_reg_out, 32'h005);
    xfer(2'b10, 3'd0, 12'h002, FL, 1'b1, rd);
    check("set_vs_hwclr", ctrl_reg_out, 32'h005);
    xfer(2'b10, 3'd0, 12'h010, FL, 1'b0, rd);
    check("set_ctrl_10", ctrl_reg_out, 32'h015);
    xfer(2'b10, 3'd0, 12'h002, FL, 1'b0, rd);
    check("set_ctrl_02", ctrl_reg_out, 32'h017);
    hw_clear_start = 1'b1;
    clk_n(1);
    hw_clear_start = 1'b0;
    clk_n(2);
    check("hwclr_alone", ctrl_reg_out, 32'h015);

`ifdef ADC_SPI_IRQ_EN
    xfer(2'b01, 3'd3, 12'h004, FL, 1'b0, rd);
    xfer(2'b00, 3'd3, 12'h000, FL, 1'b0, rd);
    check("mask_rd", rd, 32'h004);
    check("irq_idle", irq, 32'h0);
    eoc(2'd2, 12'h5A5);
    check("irq_set", irq, 32'h1);
    xfer(2'b00, 3'd6, 12'h000, FL, 1'b0, rd);
    check("data2_b", rd, 32'h5A5);
    clk_n(2);
    check("irq_clear", irq, 32'h0);
`else
    xfer(2'b01, 3'd3, 12'h004, FL, 1'b0, rd);
    xfer(2'b00, 3'd3, 12'h000, FL, 1'b0, rd);
    check("mask_rd_zero", rd, 32'h000);
    eoc(2'd2, 12'h5A5);
    check("irq_off", irq, 32'h0);
    xfer(2'b00, 3'd6, 12'h000, FL, 1'b0, rd);
    check("data2_b", rd, 32'h5A5);
    check("eoc2_cleared_b", eoc_flags_out, 32'h0);
`endif

    eoc(2'd3, 12'h333);
    cs = 1'b0;
    clk_n(6);
    shift_bits({2'b01, 3'd0, 12'h7FF}, 8, 1'b0, rd);
    reset_ = 1'b0;
    clk_n(3);
    reset_ = 1'b1;
    clk_n(4);
    check("midrst_ctrl", ctrl_reg_out, 32'h0);
    check("midrst_eoc", eoc_flags_out, 32'h0);
    shift_bits({2'b01, 3'd0, 12'h123}, FL, 1'b0, rd);
    clk_n(HALF);
    cs = 1'b1;
    clk_n(8);
    check("midrst_frame_ignored", ctrl_reg_out, 32'h0);
    xfer(2'b01, 3'd0, 12'h321, FL, 1'b0, rd);
    check("post_rst_wr", ctrl_reg_out, 32'h321);
    xfer(2'b00, 3'd0, 12'h000, FL, 1'b0, rd);
    check("post_rst_rd", rd, 32'h321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
